// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared state encodings and constants for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN  = 2'd0,
        CTRL_MDU  = 2'd1,
        CTRL_HALT = 2'd2
    } ctrl_state_t;

    localparam int          MDU_CYCLES_DEF = 4;
    localparam logic [4:0]  REG_ZERO       = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect: the ID instruction reads a register a load in EX writes.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       ex_load,
    input  logic [4:0] ex_wreg,
    output logic       lu
);

    // r0 is hardwired, so a load targeting it can never create a dependency.
    assign lu = ex_load && (ex_wreg != REG_ZERO) &&
                ((id_rs_used && (id_rs == ex_wreg)) ||
                 (id_rt_used && (id_rt == ex_wreg)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register enable/flush sequencer with stall and flush performance counters.
//   state     | meaning
//   CTRL_RUN  | normal flow; halt > redirect > MDU start > load-use
//   CTRL_MDU  | multi-cycle MDU op held in EX, front end frozen
//   CTRL_HALT | syscall halt, bubbles enter EX until resume
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             ex_load,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_redirect,
    input  logic             ex_mdu,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 1);

    ctrl_state_t state, state_nxt;
    logic [3:0]  mdu_cnt, mdu_cnt_nxt;
    logic        mdu_mask, mdu_mask_nxt;
    logic        stall_inc, flush_inc;
    logic        lu;

    load_use_detect u_lu (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .ex_load    (ex_load),
        .ex_wreg    (ex_wreg),
        .lu         (lu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CTRL_RUN;
            mdu_cnt   <= 4'd0;
            mdu_mask  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            mdu_cnt   <= mdu_cnt_nxt;
            mdu_mask  <= mdu_mask_nxt;
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, stall_inc};
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, flush_inc};
        end
    end

    always_comb begin
        state_nxt    = state;
        mdu_cnt_nxt  = mdu_cnt;
        mdu_mask_nxt = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        // Outputs are forced to the idle pattern while reset is held.
        if (!rst) begin
            case (state)
                CTRL_RUN: begin
                    if (halt_req) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        state_nxt  = CTRL_HALT;
                    end else if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (ex_mdu && !mdu_mask) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        stall_inc   = 1'b1;
                        mdu_cnt_nxt = MDU_LOAD;
                        state_nxt   = CTRL_MDU;
                    end else if (lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
                CTRL_MDU: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    stall_inc   = 1'b1;
                    mdu_cnt_nxt = mdu_cnt - 4'd1;
                    // Mask keeps the still-asserted ex_mdu from restarting the op.
                    if (mdu_cnt == 4'd1) begin
                        state_nxt    = CTRL_RUN;
                        mdu_mask_nxt = 1'b1;
                    end
                end
                CTRL_HALT: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    halted     = 1'b1;
                    if (resume) begin
                        state_nxt = CTRL_RUN;
                    end
                end
                default: begin
                    state_nxt = CTRL_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MDU_N = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, halted}
    localparam logic [6:0] O_DEF  = 7'b1101000;
    localparam logic [6:0] O_HREQ = 7'b0001100;
    localparam logic [6:0] O_HALT = 7'b0001101;
    localparam logic [6:0] O_RED  = 7'b1111100;
    localparam logic [6:0] O_MDU  = 7'b0000010;
    localparam logic [6:0] O_LU   = 7'b0001100;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [31:0] st;
        logic [31:0] fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_wreg = '0;
    logic        id_rs_used = 0, id_rt_used = 0, ex_load = 0;
    logic        ex_redirect = 0, ex_mdu = 0, halt_req = 0, resume = 0;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, halted;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;

    // Model state: halted flag, remaining MDU stall cycles, one-cycle MDU mask, counts.
    bit          m_halt = 0;
    int          m_left = 0;
    bit          m_mask = 0;
    logic [31:0] m_st = '0, m_fl = '0;

    pipe_hazard_ctrl #(.MDU_CYCLES(MDU_N), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_load(ex_load), .ex_wreg(ex_wreg), .ex_redirect(ex_redirect), .ex_mdu(ex_mdu),
        .halt_req(halt_req), .resume(resume),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Called just after a rising edge: drive one cycle, predict its outputs, advance.
    task automatic step(input bit r, input bit hr, input bit rsm, input bit red, input bit mdu,
                        input bit ld, input logic [4:0] wreg, input logic [4:0] rs,
                        input logic [4:0] rt, input bit rsu, input bit rtu);
        exp_t e;
        bit   lu_m, mask_now;
        rst = r; halt_req = hr; resume = rsm; ex_redirect = red; ex_mdu = mdu;
        ex_load = ld; ex_wreg = wreg; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        lu_m = ld && (wreg != 0) && ((rsu && rs == wreg) || (rtu && rt == wreg));
        if (r) begin
            m_halt = 0; m_left = 0; m_mask = 0; m_st = '0; m_fl = '0;
            e.ctl = O_DEF; e.st = '0; e.fl = '0;
        end else begin
            e.st = m_st; e.fl = m_fl;
            mask_now = m_mask;
            m_mask = 0;
            if (m_halt) begin
                e.ctl = O_HALT;
                if (rsm) m_halt = 0;
            end else if (m_left > 0) begin
                e.ctl = O_MDU; m_st++; m_left--;
                if (m_left == 0) m_mask = 1;
            end else if (hr) begin
                e.ctl = O_HREQ; m_halt = 1;
            end else if (red) begin
                e.ctl = O_RED; m_fl++;
            end else if (mdu && !mask_now) begin
                e.ctl = O_MDU; m_st++; m_left = MDU_N - 1;
            end else if (lu_m) begin
                e.ctl = O_LU; m_st++;
            end else begin
                e.ctl = O_DEF;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic mdu_hold(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, halted};
                total++;
                if (got !== e.ctl) begin
                    bad++;
                    $display("FAIL ctl t=%0t got=%b want=%b", $time, got, e.ctl);
                end
                total++;
                if (stall_cnt !== e.st) begin
                    bad++;
                    $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.st);
                end
                total++;
                if (flush_cnt !== e.fl) begin
                    bad++;
                    $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, flush_cnt, e.fl);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(1, 1, 0, 1, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0);
        // load-use stall, then clear
        step(0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
        idle();
        // no hazard: r0 target, or rs unused
        step(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 5'd9, 5'd0, 5'd9, 0, 1);
        // redirect beats load-use
        step(0, 0, 0, 1, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
        // MDU held: 4 stalls, masked 5th, then a restart ending in a load-use cycle
        mdu_hold(9);
        step(0, 0, 0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        idle();
        // halt for 10 cycles with noise on inputs, then resume
        step(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, i % 2, i % 3 == 0, 1, 5'd4, 5'd4, 5'd4, 1, 1);
        step(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        // reset in the middle of an MDU stall
        mdu_hold(2);
        step(1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
